// File: rtl/decode_hazard_pipe_pkg.sv
// Shared types and helpers for the decode-stage ID/EX register and its
// forwarding / load-use hazard logic.
package decode_pkg;

    typedef enum logic {RUN = 1'b0, STALL = 1'b1} fsm_state_e;

    localparam int FSEL_RF = 0;
    localparam int MAX_FWD = 32;

    // Lowest set bit among the first n entries of match; n when none is set.
    function automatic int nearest_prod(input logic [MAX_FWD-1:0] match, input int n);
        nearest_prod = n;
        for (int k = MAX_FWD - 1; k >= 0; k--) begin
            if (k < n && match[k]) nearest_prod = k;
        end
    endfunction

endpackage

// File: rtl/decode_hazard_pipe_fwd_match.sv
// Per-source producer matcher: forward select (nearest producer first) and
// the number of stall cycles a load-use hazard on this source requires.
module decode_fwd_match
    import decode_pkg::*;
#(
    parameter int NUM_FWD  = 2,
    parameter int REG_AW   = 5,
    parameter int LOAD_LAT = 1,
    parameter int FSEL_W   = $clog2(NUM_FWD + 1),
    parameter int CNT_W    = $clog2(LOAD_LAT + 1)
) (
    input  logic                            i_valid,
    input  logic                            i_use,
    input  logic [REG_AW-1:0]               i_addr,
    input  logic [NUM_FWD-1:0][REG_AW-1:0]  i_fwd_rd,
    input  logic [NUM_FWD-1:0]              i_fwd_regwrite,
    input  logic [NUM_FWD-1:0]              i_fwd_memread,
    output logic [FSEL_W-1:0]               o_fsel,
    output logic [CNT_W-1:0]                o_stall_n
);

    logic [NUM_FWD-1:0] match;
    logic [MAX_FWD-1:0] match_ext;
    int                 near;
    logic               mr_near;

    // Register 0 is hardwired, so a producer targeting it never forwards.
    for (genvar k = 0; k < NUM_FWD; k++) begin : g_match
        assign match[k] = i_fwd_regwrite[k] && (i_fwd_rd[k] != '0) && (i_fwd_rd[k] == i_addr);
    end

    assign match_ext = MAX_FWD'(match);

    always_comb begin
        near      = nearest_prod(match_ext, NUM_FWD);
        mr_near   = 1'b0;
        o_fsel    = FSEL_W'(FSEL_RF);
        o_stall_n = '0;
        for (int k = 0; k < NUM_FWD; k++) begin
            if (k == near) mr_near = i_fwd_memread[k];
        end
        if (i_use && near < NUM_FWD) begin
            o_fsel = FSEL_W'(near + 1);
            if (i_valid && mr_near && near < LOAD_LAT)
                o_stall_n = CNT_W'(LOAD_LAT - near);
        end
    end

endmodule

// File: rtl/decode_hazard_pipe.sv
// ID/EX pipeline register with forward-select generation, load-use stall FSM,
// and flush / hold / bubble control.
module decode_hazard_pipe
    import decode_pkg::*;
#(
    parameter int DATA_W   = 32,
    parameter int REG_AW   = 5,
    parameter int CTRL_W   = 16,
    parameter int NUM_FWD  = 2,
    parameter int LOAD_LAT = 1,
    parameter int FSEL_W   = $clog2(NUM_FWD + 1)
) (
    input  logic                        i_clk,
    input  logic                        i_rst,
    input  logic                        i_valid_d,
    input  logic [REG_AW-1:0]           i_addr_rs,
    input  logic [REG_AW-1:0]           i_addr_rt,
    input  logic [REG_AW-1:0]           i_addr_rd,
    input  logic                        i_use_rs,
    input  logic                        i_use_rt,
    input  logic [DATA_W-1:0]           i_data_rs,
    input  logic [DATA_W-1:0]           i_data_rt,
    input  logic [DATA_W-1:0]           i_data_imm,
    input  logic [31:0]                 i_addr_pc4,
    input  logic [CTRL_W-1:0]           i_ctrl,
    input  logic                        i_con_regwrite,
    input  logic                        i_con_memread,
    input  logic [NUM_FWD*REG_AW-1:0]   i_addr_fwd_rd,
    input  logic [NUM_FWD-1:0]          i_con_fwd_regwrite,
    input  logic [NUM_FWD-1:0]          i_con_fwd_memread,
    input  logic                        i_flush,
    input  logic                        i_hold_e,
    output logic                        o_stall_d,
    output logic                        o_valid_e,
    output logic [DATA_W-1:0]           o_data_rs,
    output logic [DATA_W-1:0]           o_data_rt,
    output logic [DATA_W-1:0]           o_data_imm,
    output logic [31:0]                 o_addr_pc4,
    output logic [REG_AW-1:0]           o_addr_rd,
    output logic [REG_AW-1:0]           o_addr_rt,
    output logic [CTRL_W-1:0]           o_ctrl,
    output logic                        o_con_regwrite,
    output logic                        o_con_memread,
    output logic [FSEL_W-1:0]           o_con_Efamux,
    output logic [FSEL_W-1:0]           o_con_Efbmux
);

    localparam int CNT_W = $clog2(LOAD_LAT + 1);

    typedef struct packed {
        logic              valid;
        logic [DATA_W-1:0] data_rs;
        logic [DATA_W-1:0] data_rt;
        logic [DATA_W-1:0] data_imm;
        logic [31:0]       addr_pc4;
        logic [REG_AW-1:0] addr_rd;
        logic [REG_AW-1:0] addr_rt;
        logic [CTRL_W-1:0] ctrl;
        logic              regwrite;
        logic              memread;
        logic [FSEL_W-1:0] fa;
        logic [FSEL_W-1:0] fb;
    } ex_t;

    ex_t        ex_q, ex_d, ld, bub;
    fsm_state_e state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d, n_max;
    logic       hazard;

    logic [NUM_FWD-1:0][REG_AW-1:0] fwd_rd;
    logic [1:0][REG_AW-1:0]         src_addr;
    logic [1:0]                     src_use;
    logic [1:0][FSEL_W-1:0]         src_fsel;
    logic [1:0][CNT_W-1:0]          src_n;

    assign fwd_rd   = i_addr_fwd_rd;
    assign src_addr = {i_addr_rt, i_addr_rs};
    assign src_use  = {i_use_rt, i_use_rs};

    // Source 0 = rs, source 1 = rt.
    for (genvar s = 0; s < 2; s++) begin : g_src
        decode_fwd_match #(
            .NUM_FWD (NUM_FWD),
            .REG_AW  (REG_AW),
            .LOAD_LAT(LOAD_LAT),
            .FSEL_W  (FSEL_W),
            .CNT_W   (CNT_W)
        ) u_match (
            .i_valid        (i_valid_d),
            .i_use          (src_use[s]),
            .i_addr         (src_addr[s]),
            .i_fwd_rd       (fwd_rd),
            .i_fwd_regwrite (i_con_fwd_regwrite),
            .i_fwd_memread  (i_con_fwd_memread),
            .o_fsel         (src_fsel[s]),
            .o_stall_n      (src_n[s])
        );
    end

    always_comb begin
        ld          = '0;
        ld.valid    = i_valid_d;
        ld.data_rs  = i_data_rs;
        ld.data_rt  = i_data_rt;
        ld.data_imm = i_data_imm;
        ld.addr_pc4 = i_addr_pc4;
        ld.addr_rd  = i_addr_rd;
        ld.addr_rt  = i_addr_rt;
        ld.ctrl     = i_ctrl;
        ld.regwrite = i_con_regwrite;
        ld.memread  = i_con_memread;
        ld.fa       = src_fsel[0];
        ld.fb       = src_fsel[1];

        bub          = ld;
        bub.valid    = 1'b0;
        bub.regwrite = 1'b0;
        bub.memread  = 1'b0;

        n_max     = (src_n[0] > src_n[1]) ? src_n[0] : src_n[1];
        hazard    = (state_q == RUN) && (n_max != '0);
        o_stall_d = !i_rst && !i_flush && (i_hold_e || state_q == STALL || hazard);

        ex_d    = ex_q;
        state_d = state_q;
        cnt_d   = cnt_q;
        if (i_flush) begin
            ex_d    = bub;
            state_d = RUN;
            cnt_d   = '0;
        end else if (i_hold_e) begin
            // everything frozen
        end else if (state_q == STALL) begin
            ex_d    = bub;
            cnt_d   = cnt_q - CNT_W'(1);
            state_d = (cnt_d == '0) ? RUN : STALL;
        end else if (hazard) begin
            // The hazard cycle itself is the first bubble, hence n-1 remaining.
            ex_d    = bub;
            cnt_d   = n_max - CNT_W'(1);
            state_d = (cnt_d != '0) ? STALL : RUN;
        end else begin
            ex_d = ld;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            ex_q    <= '0;
            state_q <= RUN;
            cnt_q   <= '0;
        end else begin
            ex_q    <= ex_d;
            state_q <= state_d;
            cnt_q   <= cnt_d;
        end
    end

    assign o_valid_e      = ex_q.valid;
    assign o_data_rs      = ex_q.data_rs;
    assign o_data_rt      = ex_q.data_rt;
    assign o_data_imm     = ex_q.data_imm;
    assign o_addr_pc4     = ex_q.addr_pc4;
    assign o_addr_rd      = ex_q.addr_rd;
    assign o_addr_rt      = ex_q.addr_rt;
    assign o_ctrl         = ex_q.ctrl;
    assign o_con_regwrite = ex_q.regwrite;
    assign o_con_memread  = ex_q.memread;
    assign o_con_Efamux   = ex_q.fa;
    assign o_con_Efbmux   = ex_q.fb;

endmodule

// File: tb/tb_decode_hazard_pipe.sv
// Directed bench: instance A (NUM_FWD=2, LOAD_LAT=1) and instance B
// (NUM_FWD=3, LOAD_LAT=2) share decode-side inputs but have their own producers.
module tb_decode_hazard_pipe;

    logic        clk = 1'b0;
    logic        rst, valid_d, use_rs, use_rt, regwrite, memread, flush, hold;
    logic [4:0]  addr_rs, addr_rt, addr_rd;
    logic [31:0] data_rs, data_rt, imm, pc4;
    logic [15:0] ctrl;

    logic [9:0]  a_fwd_rd;
    logic [1:0]  a_fwd_rw, a_fwd_mr;
    logic        a_stall, a_valid, a_rw, a_mr;
    logic [31:0] a_drs, a_drt, a_imm, a_pc4;
    logic [4:0]  a_rd, a_rt;
    logic [15:0] a_ctrl;
    logic [1:0]  a_fa, a_fb;

    logic [14:0] b_fwd_rd;
    logic [2:0]  b_fwd_rw, b_fwd_mr;
    logic        b_stall, b_valid, b_rw, b_mr;
    logic [31:0] b_drs, b_drt, b_imm, b_pc4;
    logic [4:0]  b_rd, b_rt;
    logic [15:0] b_ctrl;
    logic [1:0]  b_fa, b_fb;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    decode_hazard_pipe #(.NUM_FWD(2), .LOAD_LAT(1)) u_a (
        .i_clk(clk), .i_rst(rst), .i_valid_d(valid_d),
        .i_addr_rs(addr_rs), .i_addr_rt(addr_rt), .i_addr_rd(addr_rd),
        .i_use_rs(use_rs), .i_use_rt(use_rt),
        .i_data_rs(data_rs), .i_data_rt(data_rt), .i_data_imm(imm),
        .i_addr_pc4(pc4), .i_ctrl(ctrl),
        .i_con_regwrite(regwrite), .i_con_memread(memread),
        .i_addr_fwd_rd(a_fwd_rd), .i_con_fwd_regwrite(a_fwd_rw), .i_con_fwd_memread(a_fwd_mr),
        .i_flush(flush), .i_hold_e(hold),
        .o_stall_d(a_stall), .o_valid_e(a_valid),
        .o_data_rs(a_drs), .o_data_rt(a_drt), .o_data_imm(a_imm), .o_addr_pc4(a_pc4),
        .o_addr_rd(a_rd), .o_addr_rt(a_rt), .o_ctrl(a_ctrl),
        .o_con_regwrite(a_rw), .o_con_memread(a_mr),
        .o_con_Efamux(a_fa), .o_con_Efbmux(a_fb)
    );

    decode_hazard_pipe #(.NUM_FWD(3), .LOAD_LAT(2)) u_b (
        .i_clk(clk), .i_rst(rst), .i_valid_d(valid_d),
        .i_addr_rs(addr_rs), .i_addr_rt(addr_rt), .i_addr_rd(addr_rd),
        .i_use_rs(use_rs), .i_use_rt(use_rt),
        .i_data_rs(data_rs), .i_data_rt(data_rt), .i_data_imm(imm),
        .i_addr_pc4(pc4), .i_ctrl(ctrl),
        .i_con_regwrite(regwrite), .i_con_memread(memread),
        .i_addr_fwd_rd(b_fwd_rd), .i_con_fwd_regwrite(b_fwd_rw), .i_con_fwd_memread(b_fwd_mr),
        .i_flush(flush), .i_hold_e(hold),
        .o_stall_d(b_stall), .o_valid_e(b_valid),
        .o_data_rs(b_drs), .o_data_rt(b_drt), .o_data_imm(b_imm), .o_addr_pc4(b_pc4),
        .o_addr_rd(b_rd), .o_addr_rt(b_rt), .o_ctrl(b_ctrl),
        .o_con_regwrite(b_rw), .o_con_memread(b_mr),
        .o_con_Efamux(b_fa), .o_con_Efbmux(b_fb)
    );

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic clr_fwd();
        a_fwd_rd = '0; a_fwd_rw = '0; a_fwd_mr = '0;
        b_fwd_rd = '0; b_fwd_rw = '0; b_fwd_mr = '0;
    endtask

    // B: load producer at stage k with rd=4, instruction reads rt=4.
    task automatic b_load_at(input int k);
        b_fwd_rd = '0; b_fwd_rw = '0; b_fwd_mr = '0;
        b_fwd_rd[k*5 +: 5] = 5'd4;
        b_fwd_rw[k] = 1'b1;
        b_fwd_mr[k] = 1'b1;
    endtask

    initial begin
        // Reset with an otherwise live load-use hazard on A
        rst = 1; valid_d = 1; flush = 0; hold = 0;
        addr_rs = 3; addr_rt = 0; addr_rd = 7; use_rs = 1; use_rt = 0;
        data_rs = 32'hDEAD0001; data_rt = 32'hDEAD0002; imm = 32'h5; pc4 = 32'h100;
        ctrl = 16'hFFFF; regwrite = 1; memread = 1;
        clr_fwd();
        a_fwd_rd = {5'd0, 5'd3}; a_fwd_rw = 2'b01; a_fwd_mr = 2'b01;
        #1;
        chk("rst_a_stall", a_stall, 0);
        chk("rst_b_stall", b_stall, 0);
        tick();
        chk("rst_a_valid", a_valid, 0);
        chk("rst_a_drs", a_drs, 0);
        chk("rst_a_ctrl", a_ctrl, 0);
        chk("rst_a_rw", a_rw, 0);
        chk("rst_a_mr", a_mr, 0);
        chk("rst_b_valid", b_valid, 0);
        chk("rst_b_pc4", b_pc4, 0);

        // Basic forwarding: E rd=5, M rd=6
        rst = 0; clr_fwd();
        a_fwd_rd = {5'd6, 5'd5}; a_fwd_rw = 2'b11;
        addr_rs = 5; addr_rt = 6; addr_rd = 7; use_rs = 1; use_rt = 1;
        data_rs = 32'h11111111; data_rt = 32'h22222222; imm = 32'h33; pc4 = 32'h1004;
        ctrl = 16'hABCD; regwrite = 1; memread = 0;
        #1;
        chk("fwd_a_stall", a_stall, 0);
        tick();
        chk("fwd_a_valid", a_valid, 1);
        chk("fwd_a_fa", a_fa, 1);
        chk("fwd_a_fb", a_fb, 2);
        chk("fwd_a_drs", a_drs, 32'h11111111);
        chk("fwd_a_drt", a_drt, 32'h22222222);
        chk("fwd_a_imm", a_imm, 32'h33);
        chk("fwd_a_pc4", a_pc4, 32'h1004);
        chk("fwd_a_ctrl", a_ctrl, 16'hABCD);
        chk("fwd_a_rd", a_rd, 7);
        chk("fwd_a_rt", a_rt, 6);
        chk("fwd_a_rw", a_rw, 1);
        chk("fwd_b_fa", b_fa, 0);

        // Nearest producer wins; unused source selects 0
        a_fwd_rd = {5'd9, 5'd9}; a_fwd_rw = 2'b11;
        addr_rs = 9; addr_rt = 9; use_rt = 0;
        tick();
        chk("near_a_fa", a_fa, 1);
        chk("near_a_fb", a_fb, 0);

        // Load-use on A (LOAD_LAT=1): one bubble, then forward from M
        a_fwd_rd = {5'd0, 5'd3}; a_fwd_rw = 2'b01; a_fwd_mr = 2'b01;
        addr_rs = 3; addr_rt = 0; use_rs = 1; use_rt = 0;
        #1;
        chk("lu_a_stall", a_stall, 1);
        tick();
        chk("lu_a_bubble", a_valid, 0);
        chk("lu_a_bubble_rw", a_rw, 0);
        a_fwd_rd = {5'd3, 5'd0}; a_fwd_rw = 2'b10; a_fwd_mr = 2'b10;
        #1;
        chk("lu_a_stall_done", a_stall, 0);
        tick();
        chk("lu_a_valid", a_valid, 1);
        chk("lu_a_fa", a_fa, 2);
        chk("lu_a_rw", a_rw, 1);

        // Register zero never matches
        a_fwd_rd = '0; a_fwd_rw = 2'b01; a_fwd_mr = 2'b01;
        addr_rs = 0;
        #1;
        chk("r0_a_stall", a_stall, 0);
        tick();
        chk("r0_a_valid", a_valid, 1);
        chk("r0_a_fa", a_fa, 0);

        // Hold freezes a valid payload
        clr_fwd();
        addr_rs = 1; data_rs = 32'hAAAA0000; ctrl = 16'h1357; valid_d = 1;
        tick();
        chk("hold_a_pre", a_drs, 32'hAAAA0000);
        hold = 1; data_rs = 32'hBBBB0000; ctrl = 16'h0; valid_d = 0;
        #1;
        chk("hold_a_stall", a_stall, 1);
        tick(); tick();
        chk("hold_a_valid", a_valid, 1);
        chk("hold_a_drs", a_drs, 32'hAAAA0000);
        chk("hold_a_ctrl", a_ctrl, 16'h1357);
        hold = 0; valid_d = 1;

        // Two-cycle load on B (LOAD_LAT=2, NUM_FWD=3)
        clr_fwd(); b_load_at(0);
        addr_rs = 1; addr_rt = 4; use_rs = 1; use_rt = 1; regwrite = 1;
        #1;
        chk("l2_b_stall0", b_stall, 1);
        chk("l2_a_stall0", a_stall, 0);
        tick();
        chk("l2_b_bub0", b_valid, 0);
        chk("l2_b_bub0_rw", b_rw, 0);
        b_load_at(1);
        #1;
        chk("l2_b_stall1", b_stall, 1);
        tick();
        chk("l2_b_bub1", b_valid, 0);
        b_load_at(2);
        #1;
        chk("l2_b_stall2", b_stall, 0);
        tick();
        chk("l2_b_valid", b_valid, 1);
        chk("l2_b_fb", b_fb, 3);
        chk("l2_b_fa", b_fa, 0);
        chk("l2_b_rw", b_rw, 1);

        // Flush during STALL, then re-evaluation sees a one-cycle hazard
        b_load_at(0);
        tick();
        chk("fl_b_bub", b_valid, 0);
        b_load_at(1); flush = 1;
        #1;
        chk("fl_b_stall", b_stall, 0);
        tick();
        chk("fl_b_valid", b_valid, 0);
        chk("fl_b_rw", b_rw, 0);
        flush = 0;
        #1;
        chk("fl_b_reeval_stall", b_stall, 1);
        tick();
        chk("fl_b_reeval_bub", b_valid, 0);
        b_load_at(2);
        #1;
        chk("fl_b_stall_done", b_stall, 0);
        tick();
        chk("fl_b_valid_after", b_valid, 1);
        chk("fl_b_fb", b_fb, 3);

        // Hold for 3 cycles mid-STALL; stall completes after release
        b_load_at(0);
        tick();
        b_load_at(1); hold = 1;
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("hs_b_stall", b_stall, 1);
            tick();
            chk("hs_b_valid", b_valid, 0);
        end
        hold = 0;
        #1;
        chk("hs_b_stall_rel", b_stall, 1);
        tick();
        chk("hs_b_bub_rel", b_valid, 0);
        b_load_at(2);
        #1;
        chk("hs_b_stall_done", b_stall, 0);
        tick();
        chk("hs_b_valid", b_valid, 1);
        chk("hs_b_fb", b_fb, 3);

        // Reset mid-stall clears everything
        data_rt = 32'hCAFE0000; ctrl = 16'h2468;
        b_load_at(0);
        tick();
        chk("rs_b_in_stall", b_stall, 1);
        rst = 1;
        #1;
        chk("rs_b_stall_rst", b_stall, 0);
        tick();
        chk("rs_b_valid", b_valid, 0);
        chk("rs_b_drt", b_drt, 0);
        chk("rs_b_ctrl", b_ctrl, 0);
        chk("rs_b_fb", b_fb, 0);
        rst = 0; clr_fwd();
        #1;
        chk("rs_b_stall_post", b_stall, 0);
        tick();
        chk("rs_b_valid_post", b_valid, 1);
        chk("rs_b_drt_post", b_drt, 32'hCAFE0000);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
